axis_matvec_coproc: RTL and testbench
=====================================

AXIS_MATVEC_COPROC -- requirements
Module: axis_matvec_coproc

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_W, 8, operand and result width in bits, carried in TDATA[DATA_W-1:0].
- M_ROWS, 64, rows of matrix A, which is also the number of output words.
- N_COLS, 8, columns of A, which is also the length of vector B.
- SHIFT, 8, right-shift applied to each dot product before saturation.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- ACLK, in, 1, sole clock; all logic is on its rising edge.
- ARESETN, in, 1, reset, asynchronous and active-low.
- S_AXIS_TREADY, out, 1, coprocessor can accept an input word.
- S_AXIS_TDATA, in, 32, input word; bits above DATA_W are ignored.
- S_AXIS_TLAST, in, 1, marks the final word of a frame.
- S_AXIS_TVALID, in, 1, input word is valid.
- M_AXIS_TVALID, out, 1, output word is valid.
- M_AXIS_TDATA, out, 32, result zero-extended from DATA_W bits.
- M_AXIS_TLAST, out, 1, marks the final output word.
- M_AXIS_TREADY, in, 1, downstream can accept a word.
- err_tlast, out, 1, sticky flag for a framing error.

Function
REQ-003 The block SHALL run a five-state FSM: IDLE -> LOAD_A -> LOAD_B -> COMPUTE -> SEND -> IDLE.
REQ-004 An input transfer SHALL occur only on a cycle where S_AXIS_TVALID and S_AXIS_TREADY are both 1; S_AXIS_TREADY SHALL be 1 only in IDLE, LOAD_A and LOAD_B.
REQ-005 The first transfer SHALL move IDLE to LOAD_A; A SHALL be stored row-major (M_ROWS*N_COLS words), then B (N_COLS words) in LOAD_B.
REQ-006 The transition to COMPUTE SHALL happen on the cycle of the final B transfer, so that exactly M_ROWS*N_COLS+N_COLS words are accepted per frame.
REQ-007 COMPUTE SHALL perform one unsigned DATA_W x DATA_W multiply-accumulate per cycle.
- Accumulator width: 2*DATA_W+clog2(N_COLS) bits, so no overflow is possible.
- Each row result = min(acc >> SHIFT, 2^DATA_W-1); results are saturated, never wrapped.
REQ-008 Latency from the final B transfer to the first M_AXIS_TVALID SHALL be at most M_ROWS*N_COLS+4 cycles.
REQ-009 SEND SHALL present rows 0..M_ROWS-1 in order.
- M_AXIS_TVALID is held at 1 throughout SEND.
- TDATA is stable until the handshake, and the index advances only on TVALID & TREADY.
REQ-010 M_AXIS_TLAST SHALL be 1 exactly with row M_ROWS-1; the handshake of that word SHALL return the FSM to IDLE with TVALID=0 on the next cycle.
REQ-011 err_tlast SHALL set in either case, and SHALL clear only on reset:
- S_AXIS_TLAST=1 on any accepted word other than the final one;
- S_AXIS_TLAST=0 on the final word.
REQ-012 Framing SHALL be governed by the word count alone; TLAST errors SHALL NOT abort or resize the frame.
REQ-013 Output backpressure of any length SHALL NOT lose or duplicate words.
REQ-014 Input gaps (TVALID=0) SHALL stall loading indefinitely without corrupting storage.
REQ-015 Back-to-back frames SHALL be supported; a new frame may begin on the cycle after the last output handshake.

Reset
REQ-016 ARESETN=0 SHALL asynchronously force the following, at any time including mid-frame:
- FSM to IDLE, with all counters and the accumulator at 0;
- S_AXIS_TREADY=0, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, err_tlast=0.
REQ-017 S_AXIS_TREADY SHALL rise in the first cycle after ARESETN deasserts; RAM contents need not be cleared.

Structure
REQ-018 A shared package axis_matvec_pkg SHALL hold:
- the state enum;
- accumulator-width and counter-width functions derived from the parameters.
REQ-019 Operand storage SHALL be one sub-module, axis_mv_ram: parametrised width and depth, one write port and one synchronous read port with 1-cycle latency, instantiated for A and for B.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- M_ROWS=2, N_COLS=2, SHIFT=8; A=[255,255;128,0], B=[255,255] -> outputs 255 (130050>>8=508, saturated) then 127, TLAST on the second word, err_tlast=0.
- Default parameters with all 520 words equal to 16, sent with correct TLAST -> 64 outputs of 8 (2048>>8).
- Same as the first scenario but M_AXIS_TREADY toggles 1,0,0,1 -> exactly two outputs 255, 127, with TDATA stable while stalled.
- Same as the first scenario but TLAST on word 3 of 6 -> err_tlast=1, outputs still 255, 127.
- ARESETN pulsed low during COMPUTE of the first scenario, then that frame resent -> all outputs 0 during reset, then 255, 127 with no residue.
- Two frames back-to-back with no idle cycles -> both result sets correct and in order.

Source files
------------

// File: rtl/axis_matvec_pkg.sv
// Shared definitions for the AXI-Stream matrix-vector coprocessor.
// Holds the controller state encoding and the width helpers that the
// top level and the operand RAMs use to size counters and the accumulator.
package axis_matvec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_COMPUTE,
    ST_SEND
  } state_t;

  // Wide enough that N_COLS full-scale products can be summed without overflow.
  function automatic int acc_width(input int data_w, input int n_cols);
    return 2 * data_w + $clog2(n_cols);
  endfunction

  // Index width for a counter or address over 'depth' entries (never zero).
  function automatic int cnt_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/axis_mv_ram.sv
// Simple dual-port operand storage: one write port and one synchronous read
// port whose data appears one clock after the address is presented.
// Ports:
//   clk   - clock, rising edge
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address, sampled every cycle
//   rdata - registered read data (1-cycle latency)
module axis_mv_ram
  import axis_matvec_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset; consumers qualify rdata themselves.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/axis_matvec_coproc.sv
// AXI-Stream matrix-vector coprocessor. Accepts a frame of M_ROWS*N_COLS
// words of A (row-major) followed by N_COLS words of B, computes
// y[r] = min((sum_c A[r][c]*B[c]) >> SHIFT, 2^DATA_W-1) with one MAC per
// cycle, then streams y[0..M_ROWS-1] out with TLAST on the final row.
// Ports:
//   ACLK, ARESETN          - clock and asynchronous active-low reset
//   S_AXIS_*               - input stream (TDATA low DATA_W bits used)
//   M_AXIS_*               - output stream (TDATA zero-extended result)
//   err_tlast              - sticky flag, input TLAST disagreed with word count
module axis_matvec_coproc
  import axis_matvec_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int M_ROWS = 64,
  parameter int N_COLS = 8,
  parameter int SHIFT  = 8
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  output logic        S_AXIS_TREADY,
  input  logic [31:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TLAST,
  input  logic        S_AXIS_TVALID,
  output logic        M_AXIS_TVALID,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TLAST,
  input  logic        M_AXIS_TREADY,
  output logic        err_tlast
);

  localparam int A_DEPTH = M_ROWS * N_COLS;
  localparam int AW      = cnt_width(A_DEPTH);
  localparam int CW      = cnt_width(N_COLS);
  localparam int RW      = cnt_width(M_ROWS);
  localparam int ACC_W   = acc_width(DATA_W, N_COLS);
  localparam logic [AW-1:0]    A_LAST  = AW'(A_DEPTH - 1);
  localparam logic [CW-1:0]    C_LAST  = CW'(N_COLS - 1);
  localparam logic [RW-1:0]    R_LAST  = RW'(M_ROWS - 1);
  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'({DATA_W{1'b1}});

  state_t              state;
  logic [AW-1:0]       a_idx;
  logic [CW-1:0]       col_idx;
  logic [RW-1:0]       row_idx;
  logic                iss_active;
  logic                p_valid;
  logic                p_last;
  logic [RW-1:0]       p_row;
  logic [ACC_W-1:0]    acc;
  logic                s_tready;
  logic                m_tvalid;
  logic                m_tlast;
  logic [DATA_W-1:0]   m_tdata;
  logic                err_q;
  logic [DATA_W-1:0]   res_mem [M_ROWS];

  logic [DATA_W-1:0]   in_word;
  logic [DATA_W-1:0]   a_rdata;
  logic [DATA_W-1:0]   b_rdata;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    acc_sum;
  logic [ACC_W-1:0]    shifted;
  logic [DATA_W-1:0]   sat_val;
  logic                s_fire;
  logic                m_fire;
  logic                a_we;
  logic                b_we;
  logic                final_word;
  logic                unused_tdata_hi;

  assign in_word         = S_AXIS_TDATA[DATA_W-1:0];
  assign unused_tdata_hi = ^S_AXIS_TDATA[31:DATA_W];
  assign s_fire          = S_AXIS_TVALID & s_tready;
  assign m_fire          = m_tvalid & M_AXIS_TREADY;
  assign a_we            = s_fire && (state == ST_IDLE || state == ST_LOAD_A);
  assign b_we            = s_fire && (state == ST_LOAD_B);
  assign final_word      = (state == ST_LOAD_B) && (col_idx == C_LAST);

  // a_idx doubles as write address while loading and read address while
  // computing; likewise col_idx for B. The phases never overlap.
  axis_mv_ram #(.WIDTH(DATA_W), .DEPTH(A_DEPTH)) u_ram_a (
    .clk   (ACLK),
    .we    (a_we),
    .waddr (a_idx),
    .wdata (in_word),
    .raddr (a_idx),
    .rdata (a_rdata)
  );

  axis_mv_ram #(.WIDTH(DATA_W), .DEPTH(N_COLS)) u_ram_b (
    .clk   (ACLK),
    .we    (b_we),
    .waddr (col_idx),
    .wdata (in_word),
    .raddr (col_idx),
    .rdata (b_rdata)
  );

  // MAC datapath on the RAM outputs, with saturation of the scaled sum.
  always_comb begin
    prod    = a_rdata * b_rdata;
    acc_sum = acc + ACC_W'(prod);
    shifted = acc_sum >> SHIFT;
    sat_val = (shifted > SAT_MAX) ? {DATA_W{1'b1}} : shifted[DATA_W-1:0];
  end

  // Row results are parked here until SEND; no reset needed.
  always_ff @(posedge ACLK) begin
    if (state == ST_COMPUTE && p_valid && p_last) begin
      res_mem[p_row] <= sat_val;
    end
  end

  // Controller. COMPUTE is a two-stage pipe: the issue stage walks the RAM
  // addresses, and p_* tags the data that emerges from the RAMs a cycle later.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state      <= ST_IDLE;
      a_idx      <= '0;
      col_idx    <= '0;
      row_idx    <= '0;
      iss_active <= 1'b0;
      p_valid    <= 1'b0;
      p_last     <= 1'b0;
      p_row      <= '0;
      acc        <= '0;
      s_tready   <= 1'b0;
      m_tvalid   <= 1'b0;
      m_tlast    <= 1'b0;
      m_tdata    <= '0;
      err_q      <= 1'b0;
    end else begin
      // Framing is decided by the word count; TLAST only feeds the flag.
      if (s_fire && (S_AXIS_TLAST != final_word)) begin
        err_q <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          s_tready <= 1'b1;
          if (s_fire) begin
            if (A_DEPTH == 1) begin
              state <= ST_LOAD_B;
            end else begin
              a_idx <= AW'(1);
              state <= ST_LOAD_A;
            end
          end
        end

        ST_LOAD_A: begin
          if (s_fire) begin
            if (a_idx == A_LAST) begin
              a_idx <= '0;
              state <= ST_LOAD_B;
            end else begin
              a_idx <= a_idx + AW'(1);
            end
          end
        end

        ST_LOAD_B: begin
          if (s_fire) begin
            if (col_idx == C_LAST) begin
              col_idx    <= '0;
              s_tready   <= 1'b0;
              iss_active <= 1'b1;
              state      <= ST_COMPUTE;
            end else begin
              col_idx <= col_idx + CW'(1);
            end
          end
        end

        ST_COMPUTE: begin
          p_valid <= iss_active;
          p_last  <= (col_idx == C_LAST);
          p_row   <= row_idx;
          if (iss_active) begin
            if (a_idx == A_LAST) begin
              iss_active <= 1'b0;
              a_idx      <= '0;
              col_idx    <= '0;
              row_idx    <= '0;
            end else begin
              a_idx <= a_idx + AW'(1);
              if (col_idx == C_LAST) begin
                col_idx <= '0;
                row_idx <= row_idx + RW'(1);
              end else begin
                col_idx <= col_idx + CW'(1);
              end
            end
          end
          if (p_valid) begin
            if (p_last) begin
              acc <= '0;
              if (p_row == R_LAST) begin
                // Row 0 may be the result being finished right now (M_ROWS=1).
                state    <= ST_SEND;
                p_valid  <= 1'b0;
                row_idx  <= '0;
                m_tvalid <= 1'b1;
                m_tlast  <= (M_ROWS == 1);
                m_tdata  <= (p_row == '0) ? sat_val : res_mem[0];
              end
            end else begin
              acc <= acc_sum;
            end
          end
        end

        ST_SEND: begin
          if (m_fire) begin
            if (row_idx == R_LAST) begin
              state    <= ST_IDLE;
              m_tvalid <= 1'b0;
              m_tlast  <= 1'b0;
              row_idx  <= '0;
              s_tready <= 1'b1;
            end else begin
              row_idx <= row_idx + RW'(1);
              m_tdata <= res_mem[row_idx + RW'(1)];
              m_tlast <= ((row_idx + RW'(1)) == R_LAST);
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign S_AXIS_TREADY = s_tready;
  assign M_AXIS_TVALID = m_tvalid;
  assign M_AXIS_TLAST  = m_tlast;
  assign M_AXIS_TDATA  = 32'(m_tdata);
  assign err_tlast     = err_q;

endmodule

// File: tb/tb_axis_matvec_coproc.sv
// Self-checking bench for axis_matvec_coproc. Two instances: a 2x2 one for
// the small directed frames and one with default parameters. An expected
// output queue per instance is filled from a plain arithmetic model of
// y = sat((A*B) >> SHIFT); one compare process pops it on every output
// handshake and also checks that TDATA holds while the sink stalls.
module tb_axis_matvec_coproc;

  localparam int MAXV = 255;

  logic        ACLK;
  logic        ARESETN;

  logic        s_tready_s, s_tvalid_s, s_tlast_s;
  logic [31:0] s_tdata_s;
  logic        m_tvalid_s, m_tlast_s, m_tready_s, err_s;
  logic [31:0] m_tdata_s;

  logic        s_tready_d, s_tvalid_d, s_tlast_d;
  logic [31:0] s_tdata_d;
  logic        m_tvalid_d, m_tlast_d, m_tready_d, err_d;
  logic [31:0] m_tdata_d;

  int tests = 0;
  int fails = 0;

  int exp_data_s[$];
  int exp_last_s[$];
  int exp_data_d[$];
  int exp_last_d[$];
  int got_s[$];
  int got_d[$];
  int err_exp_s = 0;
  int err_exp_d = 0;

  logic        hold_s = 1'b0;
  logic [31:0] held_s = '0;
  logic        hold_d = 1'b0;
  logic [31:0] held_d = '0;
  int          stalls_s = 0;

  logic        pat_en = 1'b0;
  logic [3:0]  pat = 4'b1001;
  int          pat_i = 0;

  axis_matvec_coproc #(.DATA_W(8), .M_ROWS(2), .N_COLS(2), .SHIFT(8)) dut_s (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .S_AXIS_TREADY (s_tready_s),
    .S_AXIS_TDATA  (s_tdata_s),
    .S_AXIS_TLAST  (s_tlast_s),
    .S_AXIS_TVALID (s_tvalid_s),
    .M_AXIS_TVALID (m_tvalid_s),
    .M_AXIS_TDATA  (m_tdata_s),
    .M_AXIS_TLAST  (m_tlast_s),
    .M_AXIS_TREADY (m_tready_s),
    .err_tlast     (err_s)
  );

  axis_matvec_coproc dut_d (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .S_AXIS_TREADY (s_tready_d),
    .S_AXIS_TDATA  (s_tdata_d),
    .S_AXIS_TLAST  (s_tlast_d),
    .S_AXIS_TVALID (s_tvalid_d),
    .M_AXIS_TVALID (m_tvalid_d),
    .M_AXIS_TDATA  (m_tdata_d),
    .M_AXIS_TLAST  (m_tlast_d),
    .M_AXIS_TREADY (m_tready_d),
    .err_tlast     (err_d)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  // Watchdog so a wedged design still ends the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, fails so far %0d", fails);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: y[r] = min((sum_c A[r][c]*B[c]) >> shift, 255).
  function automatic void modelFrame(input int sel, input int words[$], input int m,
                                     input int n, input int shift, input int tlast_pos);
    longint acc;
    int     y;
    for (int r = 0; r < m; r++) begin
      acc = 0;
      for (int c = 0; c < n; c++) begin
        acc += longint'(words[r*n + c]) * longint'(words[m*n + c]);
      end
      y = ((acc >> shift) > MAXV) ? MAXV : int'(acc >> shift);
      if (sel == 0) begin
        exp_data_s.push_back(y);
        exp_last_s.push_back(r == m - 1 ? 1 : 0);
      end else begin
        exp_data_d.push_back(y);
        exp_last_d.push_back(r == m - 1 ? 1 : 0);
      end
    end
    if (tlast_pos != words.size() - 1) begin
      if (sel == 0) err_exp_s = 1;
      else          err_exp_d = 1;
    end
  endfunction

  function automatic logic readyOf(input int sel);
    return (sel == 0) ? s_tready_s : s_tready_d;
  endfunction

  // Drives one frame, holding TVALID high between words and across frames.
  // Upper TDATA bits carry junk that the design has to ignore.
  task automatic applyStimulus(input int sel, input int words[$], input int tlast_pos);
    foreach (words[i]) begin
      int guard;
      @(negedge ACLK);
      if (sel == 0) begin
        s_tvalid_s = 1'b1;
        s_tdata_s  = 32'hDEAD_0000 | 32'(words[i]);
        s_tlast_s  = (i == tlast_pos);
      end else begin
        s_tvalid_d = 1'b1;
        s_tdata_d  = 32'hBEEF_0000 | 32'(words[i]);
        s_tlast_d  = (i == tlast_pos);
      end
      guard = 0;
      while (!readyOf(sel) && guard < 5000) begin
        @(negedge ACLK);
        guard++;
      end
      if (guard >= 5000) begin
        checkOutput("s_tready_timeout", 0, 1);
        return;
      end
    end
  endtask

  task automatic idleInputs();
    @(negedge ACLK);
    s_tvalid_s = 1'b0;
    s_tlast_s  = 1'b0;
    s_tvalid_d = 1'b0;
    s_tlast_d  = 1'b0;
  endtask

  task automatic waitDrain(input int sel, input int budget);
    int k = 0;
    while (((sel == 0) ? exp_data_s.size() : exp_data_d.size()) != 0 && k < budget) begin
      @(negedge ACLK);
      k++;
    end
    checkOutput("drain_pending_words", (sel == 0) ? exp_data_s.size() : exp_data_d.size(), 0);
    repeat (3) @(negedge ACLK);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_s_tready"}, int'(s_tready_s), 0);
    checkOutput({tag, "_s_tvalid"}, int'(m_tvalid_s), 0);
    checkOutput({tag, "_s_tlast"},  int'(m_tlast_s), 0);
    checkOutput({tag, "_s_tdata"},  int'(m_tdata_s), 0);
    checkOutput({tag, "_s_err"},    int'(err_s), 0);
    checkOutput({tag, "_d_tready"}, int'(s_tready_d), 0);
    checkOutput({tag, "_d_tvalid"}, int'(m_tvalid_d), 0);
    checkOutput({tag, "_d_tdata"},  int'(m_tdata_d), 0);
  endtask

  // Sink-side pacing for the backpressure scenario: 1,0,0,1 repeating.
  initial begin
    forever begin
      @(posedge ACLK);
      #1;
      if (pat_en) begin
        m_tready_s = pat[pat_i];
        pat_i = (pat_i + 1) % 4;
      end
    end
  end

  // Compare process: every output handshake against the model queues,
  // plus TDATA/TVALID stability on the cycle after any stall.
  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (hold_s) begin
        checkOutput("stall_tvalid_s", int'(m_tvalid_s), 1);
        checkOutput("stall_tdata_s", int'(m_tdata_s), int'(held_s));
      end
      if (m_tvalid_s && m_tready_s) begin
        if (exp_data_s.size() == 0) begin
          checkOutput("unexpected_word_s", int'(m_tdata_s), -1);
        end else begin
          checkOutput("tdata_s", int'(m_tdata_s), exp_data_s.pop_front());
          checkOutput("tlast_s", int'(m_tlast_s), exp_last_s.pop_front());
          got_s.push_back(int'(m_tdata_s));
        end
      end
      if (hold_d) begin
        checkOutput("stall_tdata_d", int'(m_tdata_d), int'(held_d));
      end
      if (m_tvalid_d && m_tready_d) begin
        if (exp_data_d.size() == 0) begin
          checkOutput("unexpected_word_d", int'(m_tdata_d), -1);
        end else begin
          checkOutput("tdata_d", int'(m_tdata_d), exp_data_d.pop_front());
          checkOutput("tlast_d", int'(m_tlast_d), exp_last_d.pop_front());
          got_d.push_back(int'(m_tdata_d));
        end
      end
      hold_s   <= m_tvalid_s && !m_tready_s;
      held_s   <= m_tdata_s;
      hold_d   <= m_tvalid_d && !m_tready_d;
      held_d   <= m_tdata_d;
      if (m_tvalid_s && !m_tready_s) stalls_s <= stalls_s + 1;
    end else begin
      hold_s <= 1'b0;
      hold_d <= 1'b0;
    end
  end

  initial begin
    int f1[$];
    int f2[$];
    int fd[$];
    int k;

    f1 = '{255, 255, 128, 0, 255, 255};
    f2 = '{200, 100, 50, 25, 10, 20};
    for (int i = 0; i < 520; i++) fd.push_back(16);

    ARESETN    = 1'b0;
    s_tvalid_s = 1'b0; s_tlast_s = 1'b0; s_tdata_s = '0; m_tready_s = 1'b1;
    s_tvalid_d = 1'b0; s_tlast_d = 1'b0; s_tdata_d = '0; m_tready_d = 1'b1;

    // Reset state, then TREADY must rise one cycle after release.
    repeat (3) @(negedge ACLK);
    checkResetOutputs("reset");
    ARESETN = 1'b1;
    @(negedge ACLK);
    checkOutput("tready_after_reset_s", int'(s_tready_s), 1);
    checkOutput("tready_after_reset_d", int'(s_tready_d), 1);

    // 2x2 reference frame: 130050>>8 = 508 saturates to 255, 32640>>8 = 127.
    got_s.delete();
    modelFrame(0, f1, 2, 2, 8, 5);
    applyStimulus(0, f1, 5);
    idleInputs();
    waitDrain(0, 200);
    checkOutput("basic_count", got_s.size(), 2);
    checkOutput("basic_y0", got_s.size() > 0 ? got_s[0] : -1, 255);
    checkOutput("basic_y1", got_s.size() > 1 ? got_s[1] : -1, 127);
    checkOutput("basic_err", int'(err_s), err_exp_s);
    checkOutput("basic_idle_tvalid", int'(m_tvalid_s), 0);

    // Default 64x8 frame of all 16s: 8*256 = 2048, >>8 = 8 on every row.
    got_d.delete();
    modelFrame(1, fd, 64, 8, 8, 519);
    applyStimulus(1, fd, 519);
    idleInputs();
    waitDrain(1, 2000);
    checkOutput("dflt_count", got_d.size(), 64);
    checkOutput("dflt_y0", got_d.size() > 0 ? got_d[0] : -1, 8);
    checkOutput("dflt_y63", got_d.size() > 63 ? got_d[63] : -1, 8);
    checkOutput("dflt_err", int'(err_d), 0);

    // Output backpressure with a guaranteed stall on each word.
    got_s.delete();
    m_tready_s = 1'b0;
    modelFrame(0, f1, 2, 2, 8, 5);
    applyStimulus(0, f1, 5);
    idleInputs();
    k = 0;
    while (!m_tvalid_s && k < 100) begin
      @(negedge ACLK);
      k++;
    end
    checkOutput("bp_tvalid_seen", int'(m_tvalid_s), 1);
    pat_i  = 0;
    pat_en = 1'b1;
    waitDrain(0, 200);
    pat_en = 1'b0;
    m_tready_s = 1'b1;
    checkOutput("bp_count", got_s.size(), 2);
    checkOutput("bp_y0", got_s.size() > 0 ? got_s[0] : -1, 255);
    checkOutput("bp_y1", got_s.size() > 1 ? got_s[1] : -1, 127);
    checkOutput("bp_stalls_seen", int'(stalls_s > 0), 1);

    // Back-to-back frames; f2 gives 4000>>8 = 15 and 1000>>8 = 3.
    got_s.delete();
    modelFrame(0, f1, 2, 2, 8, 5);
    modelFrame(0, f2, 2, 2, 8, 5);
    applyStimulus(0, f1, 5);
    applyStimulus(0, f2, 5);
    idleInputs();
    waitDrain(0, 400);
    checkOutput("b2b_count", got_s.size(), 4);
    checkOutput("b2b_y2", got_s.size() > 2 ? got_s[2] : -1, 15);
    checkOutput("b2b_y3", got_s.size() > 3 ? got_s[3] : -1, 3);
    checkOutput("b2b_err", int'(err_s), err_exp_s);

    // TLAST on word 3 of 6: flag sets, framing and results unaffected.
    got_s.delete();
    modelFrame(0, f1, 2, 2, 8, 2);
    applyStimulus(0, f1, 2);
    idleInputs();
    waitDrain(0, 200);
    checkOutput("tlerr_flag", int'(err_s), 1);
    checkOutput("tlerr_model_flag", int'(err_s), err_exp_s);
    checkOutput("tlerr_y0", got_s.size() > 0 ? got_s[0] : -1, 255);
    checkOutput("tlerr_y1", got_s.size() > 1 ? got_s[1] : -1, 127);

    // Reset during COMPUTE, then resend the same frame.
    got_s.delete();
    applyStimulus(0, f1, 5);
    idleInputs();
    @(negedge ACLK);
    ARESETN = 1'b0;
    #1;
    checkResetOutputs("midreset");
    err_exp_s = 0;
    err_exp_d = 0;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (10) @(negedge ACLK);
    checkOutput("midreset_no_residue", got_s.size(), 0);
    modelFrame(0, f1, 2, 2, 8, 5);
    applyStimulus(0, f1, 5);
    idleInputs();
    waitDrain(0, 200);
    checkOutput("resend_count", got_s.size(), 2);
    checkOutput("resend_y0", got_s.size() > 0 ? got_s[0] : -1, 255);
    checkOutput("resend_y1", got_s.size() > 1 ? got_s[1] : -1, 127);
    checkOutput("resend_err", int'(err_s), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
